// File: rtl/stream_cmp.sv
// Lock-step comparator for LANES valid/data streams: counts beats and bursts, latches the
// first inconsistency, and signals done after TAIL_CYCLES idle samples. Define STREAM_CMP_XCHECK_EN for X/Z checking.
module stream_cmp #(
    parameter int LANES       = 3,
    parameter int DW          = 4,
    parameter int TAIL_CYCLES = 3,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LANES-1:0]   valid_i,
    input  logic [LANES*DW-1:0] data_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [1:0]         err_code_o,
    output logic [LANES-1:0]   err_lanes_o,
    output logic [DW-1:0]      err_data_o,
    output logic [CNT_W-1:0]   beats_o,
    output logic [CNT_W-1:0]   bursts_o
);

    localparam int TW = $clog2(TAIL_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_TAIL,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      idle_q, idle_d;
    logic [CNT_W-1:0]   beats_q, beats_d;
    logic [CNT_W-1:0]   bursts_q, bursts_d;
    logic [1:0]         code_q, code_d;
    logic [LANES-1:0]   lanes_q, lanes_d;
    logic [DW-1:0]      edata_q, edata_d;
    logic               busy_q, done_q, err_q;

    logic [LANES-1:0]   diff_lane;
    logic [LANES-1:0]   skew_lane;
    logic               all_v, none_v, skew, mism;
    logic [1:0]         fault_code;
    logic [LANES-1:0]   fault_lanes;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign diff_lane[gi] = (data_i[gi*DW +: DW] != data_i[0 +: DW]);
        assign skew_lane[gi] = (valid_i[gi] != valid_i[0]);
    end

    assign all_v  = &valid_i;
    assign none_v = ~|valid_i;
    assign skew   = !all_v && !none_v;
    assign mism   = all_v && (|diff_lane);

`ifdef STREAM_CMP_XCHECK_EN
    logic [LANES-1:0] x_lane;
    for (genvar gi = 0; gi < LANES; gi++) begin : g_xchk
        assign x_lane[gi] = $isunknown(valid_i[gi]) ||
                            ((valid_i[gi] === 1'b1) && $isunknown(data_i[gi*DW +: DW]));
    end
`endif

    // Fault classification; skew outranks mism since data on invalid lanes is meaningless.
    always_comb begin
        fault_code  = 2'd0;
        fault_lanes = '0;
`ifdef STREAM_CMP_XCHECK_EN
        if (|x_lane) begin
            fault_code  = 2'd3;
            fault_lanes = x_lane;
        end else
`endif
        if (skew) begin
            fault_code  = 2'd1;
            fault_lanes = skew_lane;
        end else if (mism) begin
            fault_code  = 2'd2;
            fault_lanes = diff_lane;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d  = state_q;
        idle_d   = idle_q;
        beats_d  = beats_q;
        bursts_d = bursts_q;
        code_d   = code_q;
        lanes_d  = lanes_q;
        edata_d  = edata_q;

        if ((state_q != ST_DONE) && (state_q != ST_ERROR) && (fault_code != 2'd0)) begin
            state_d = ST_ERROR;
            code_d  = fault_code;
            lanes_d = fault_lanes;
            edata_d = data_i[0 +: DW];
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (all_v) begin
                        state_d  = ST_ACTIVE;
                        beats_d  = sat_inc(beats_q);
                        bursts_d = sat_inc(bursts_q);
                    end
                end
                ST_ACTIVE: begin
                    if (all_v) begin
                        beats_d = sat_inc(beats_q);
                    end else if (TAIL_CYCLES == 1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_TAIL;
                        idle_d  = TW'(1);
                    end
                end
                ST_TAIL: begin
                    if (all_v) begin
                        state_d  = ST_ACTIVE;
                        idle_d   = '0;
                        beats_d  = sat_inc(beats_q);
                        bursts_d = sat_inc(bursts_q);
                    end else if (idle_q == TW'(TAIL_CYCLES - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idle_q   <= '0;
            beats_q  <= '0;
            bursts_q <= '0;
            code_q   <= '0;
            lanes_q  <= '0;
            edata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            beats_q  <= beats_d;
            bursts_q <= bursts_d;
            code_q   <= code_d;
            lanes_q  <= lanes_d;
            edata_q  <= edata_d;
            busy_q   <= (state_d == ST_ACTIVE) || (state_d == ST_TAIL);
            done_q   <= (state_d == ST_DONE);
            err_q    <= (state_d == ST_ERROR);
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_code_o  = code_q;
    assign err_lanes_o = lanes_q;
    assign err_data_o  = edata_q;
    assign beats_o     = beats_q;
    assign bursts_o    = bursts_q;

endmodule
